// File: rtl/thresh_mon_pkg.sv
// Shared definitions for the threshold monitor: FSM state encoding and
// default counter widths.
package thresh_mon_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_PEND_HI = 2'd1,
        ST_ALARM   = 2'd2,
        ST_PEND_LO = 2'd3
    } mon_state_e;

    localparam int CNT_W_DEF = 4;
    localparam int EVT_W_DEF = 8;

endpackage

// File: rtl/cmp8.sv
// Unsigned 8-bit magnitude comparator.
module cmp8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       gt,
    output logic       lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/thresh_mon8.sv
// Debounced high/low threshold alarm: a run of cnt_lim consecutive hits above
// thr_hi raises the alarm, a run below thr_lo clears it.
module thresh_mon8
    import thresh_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int EVT_W = EVT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic [7:0]       thr_hi,
    input  logic [7:0]       thr_lo,
    input  logic [CNT_W-1:0] cnt_lim,
    output logic             alarm,
    output logic             alarm_rise,
    output logic             alarm_fall,
    output logic [CNT_W-1:0] run_cnt,
    output logic [EVT_W-1:0] evt_cnt
);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic             alarm_q, alarm_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    logic             hi_hit, lo_hit;
    logic             hi_lt_unused, lo_gt_unused;
    logic [CNT_W-1:0] lim_eff;
    logic [CNT_W:0]   run_inc;
    logic             lim_one;
    logic             run_done;

    function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
        return (v == {EVT_W{1'b1}}) ? v : v + EVT_W'(1);
    endfunction

    cmp8 u_cmp_hi (
        .a  (in_data),
        .b  (thr_hi),
        .gt (hi_hit),
        .lt (hi_lt_unused)
    );

    cmp8 u_cmp_lo (
        .a  (in_data),
        .b  (thr_lo),
        .gt (lo_gt_unused),
        .lt (lo_hit)
    );

    // A zero limit would never complete a run, so it behaves as one.
    assign lim_eff  = (cnt_lim == '0) ? CNT_W'(1) : cnt_lim;
    assign lim_one  = (lim_eff == CNT_W'(1));
    assign run_inc  = {1'b0, run_q} + (CNT_W+1)'(1);
    // >= rather than == so a limit lowered mid-run still completes the run.
    assign run_done = (run_inc >= {1'b0, lim_eff});

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                ST_NORMAL: begin
                    run_d = '0;
                    if (hi_hit) begin
                        if (lim_one) begin
                            state_d = ST_ALARM;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = ST_PEND_HI;
                            run_d   = CNT_W'(1);
                        end
                    end
                end
                ST_PEND_HI: begin
                    run_d   = '0;
                    state_d = ST_NORMAL;
                    if (hi_hit) begin
                        if (run_done) begin
                            state_d = ST_ALARM;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = ST_PEND_HI;
                            run_d   = run_inc[CNT_W-1:0];
                        end
                    end
                end
                ST_ALARM: begin
                    run_d = '0;
                    if (lo_hit) begin
                        if (lim_one) begin
                            state_d = ST_NORMAL;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = ST_PEND_LO;
                            run_d   = CNT_W'(1);
                        end
                    end
                end
                ST_PEND_LO: begin
                    run_d   = '0;
                    state_d = ST_ALARM;
                    if (lo_hit) begin
                        if (run_done) begin
                            state_d = ST_NORMAL;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = ST_PEND_LO;
                            run_d   = run_inc[CNT_W-1:0];
                        end
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                    run_d   = '0;
                end
            endcase
        end
    end

    assign evt_d   = rise_d ? sat_inc(evt_q) : evt_q;
    assign alarm_d = (state_d == ST_ALARM) || (state_d == ST_PEND_LO);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_NORMAL;
            run_q   <= '0;
            evt_q   <= '0;
            alarm_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            evt_q   <= evt_d;
            alarm_q <= alarm_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign alarm      = alarm_q;
    assign alarm_rise = rise_q;
    assign alarm_fall = fall_q;
    assign run_cnt    = run_q;
    assign evt_cnt    = evt_q;

endmodule
